// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the data memory controller:
// FSM state encoding, RISC-V funct3 size codes and load extension.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Reserved load encodings fall through to a full word.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] word);
        case (f3)
            F3_B:    return {{24{word[7]}}, word[7:0]};
            F3_BU:   return {24'h0, word[7:0]};
            F3_H:    return {{16{word[15]}}, word[15:0]};
            F3_HU:   return {16'h0, word[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer
// and advances the pointer past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_enable,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_winner
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;
    int               w_idx;

    always_comb begin
        o_gnt    = '0;
        o_winner = r_ptr;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && i_req[IDX_W'(w_idx)]) begin
                w_found  = 1'b1;
                o_winner = IDX_W'(w_idx);
            end
        end
        if (i_enable && w_found) begin
            o_gnt[o_winner] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_enable && w_found) begin
            r_ptr <= (int'(o_winner) == N_REQ - 1) ? '0 : o_winner + 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: arbitrates a single-port byte memory between
// requesters and runs sized RISC-V loads/stores, one transaction at a time.
module data_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter  int A_WIDTH = 28,
    parameter  int D_WIDTH = 32,
    parameter  int N_REQ   = 2,
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [N_REQ-1:0]                i_req,
    input  logic [N_REQ-1:0]                i_req_we,
    input  logic [N_REQ-1:0][2:0]           i_req_f3,
    input  logic [N_REQ-1:0][A_WIDTH-1:0]   i_req_addr,
    input  logic [N_REQ-1:0][D_WIDTH-1:0]   i_req_wdata,
    output logic [N_REQ-1:0]                o_gnt,
    output logic [N_REQ-1:0]                o_resp,
    output logic [D_WIDTH-1:0]              o_rdata,
    output logic [A_WIDTH-1:0]              o_mem_a,
    output logic [D_WIDTH-1:0]              o_mem_wd,
    output logic                            o_mem_we,
    input  logic [D_WIDTH-1:0]              i_mem_rd
);

    state_t             r_state;
    state_t             w_next;
    logic               r_we;
    logic [2:0]         r_f3;
    logic [A_WIDTH-1:0] r_addr;
    logic [D_WIDTH-1:0] r_wdata;
    logic [D_WIDTH-1:0] r_merge;
    logic [D_WIDTH-1:0] r_rdata;
    logic [IDX_W-1:0]   r_owner;

    logic [N_REQ-1:0]   w_gnt;
    logic [IDX_W-1:0]   w_winner;
    logic               w_enable;
    logic [2:0]         w_win_f3;

    // Grants are only offered while idle and never while reset is held.
    assign w_enable = (r_state == IDLE) && i_rst_n;
    assign w_win_f3 = i_req_f3[w_winner];

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req),
        .i_enable (w_enable),
        .o_gnt    (w_gnt),
        .o_winner (w_winner)
    );

    assign o_gnt   = w_gnt;
    assign o_rdata = r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_merge <= '0;
            r_rdata <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_we    <= i_req_we[w_winner];
                        r_f3    <= w_win_f3;
                        r_addr  <= i_req_addr[w_winner];
                        r_wdata <= i_req_wdata[w_winner];
                        r_owner <= w_winner;
                    end
                end
                RD: r_rdata <= extend(r_f3, i_mem_rd);
                // Keep the bytes above the store width exactly as read back.
                RMW_RD: r_merge <= (r_f3 == F3_B) ? {i_mem_rd[31:8], r_wdata[7:0]}
                                                  : {i_mem_rd[31:16], r_wdata[15:0]};
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next   = r_state;
        o_mem_a  = '0;
        o_mem_wd = '0;
        o_mem_we = 1'b0;
        o_resp   = '0;
        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    if (!i_req_we[w_winner]) begin
                        w_next = RD;
                    end else if (w_win_f3 == F3_B || w_win_f3 == F3_H) begin
                        w_next = RMW_RD;
                    end else begin
                        w_next = WR;
                    end
                end
            end
            RD: begin
                o_mem_a = r_addr;
                w_next  = DONE;
            end
            WR: begin
                o_mem_a  = r_addr;
                o_mem_wd = r_wdata;
                o_mem_we = 1'b1;
                w_next   = DONE;
            end
            RMW_RD: begin
                o_mem_a = r_addr;
                w_next  = RMW_WR;
            end
            RMW_WR: begin
                o_mem_a  = r_addr;
                o_mem_wd = r_merge;
                o_mem_we = 1'b1;
                w_next   = DONE;
            end
            DONE: begin
                o_resp[r_owner] = 1'b1;
                w_next          = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte RAM on the memory port, a transaction-level
// reference model checked every cycle, plus directed literal checks.
module tb_data_mem_ctrl;

    logic              clk = 1'b0;
    logic              rstN;
    logic [1:0]        req;
    logic [1:0]        reqWe;
    logic [1:0][2:0]   reqF3;
    logic [1:0][27:0]  reqAddr;
    logic [1:0][31:0]  reqWdata;
    logic [1:0]        gnt;
    logic [1:0]        resp;
    logic [31:0]       rdata;
    logic [27:0]       memA;
    logic [31:0]       memWd;
    logic              memWe;
    logic [31:0]       memRd;

    logic [7:0]        ram    [0:1023];
    logic [7:0]        refMem [0:1023];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.A_WIDTH(28), .D_WIDTH(32), .N_REQ(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_req       (req),
        .i_req_we    (reqWe),
        .i_req_f3    (reqF3),
        .i_req_addr  (reqAddr),
        .i_req_wdata (reqWdata),
        .o_gnt       (gnt),
        .o_resp      (resp),
        .o_rdata     (rdata),
        .o_mem_a     (memA),
        .o_mem_wd    (memWd),
        .o_mem_we    (memWe),
        .i_mem_rd    (memRd)
    );

    // Behavioural byte RAM: combinational read, posedge write, little-endian.
    logic [9:0] ramIdx;
    always_comb begin
        ramIdx = memA[9:0];
        memRd  = {ram[ramIdx + 10'd3], ram[ramIdx + 10'd2], ram[ramIdx + 10'd1], ram[ramIdx]};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memWe) begin
            ram[ramIdx]         <= memWd[7:0];
            ram[ramIdx + 10'd1] <= memWd[15:8];
            ram[ramIdx + 10'd2] <= memWd[23:16];
            ram[ramIdx + 10'd3] <= memWd[31:24];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] refWord(input logic [27:0] a);
        logic [9:0] i;
        i = a[9:0];
        return {refMem[i + 10'd3], refMem[i + 10'd2], refMem[i + 10'd1], refMem[i]};
    endfunction

    function automatic logic [31:0] loadValue(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'd0:    return 32'($signed(w[7:0]));
            3'd4:    return 32'(w[7:0]);
            3'd1:    return 32'($signed(w[15:0]));
            3'd5:    return 32'(w[15:0]);
            default: return w;
        endcase
    endfunction

    // Reference model: grant order, latency, memory port activity and results.
    bit          pending = 1'b0;
    bit          wasPending;
    int          cnt = 0;
    int          rrPtr = 0;
    int          mPort;
    int          win;
    bit          mWe;
    bit          mSub;
    logic [2:0]  mF3;
    logic [27:0] mAddr;
    logic [31:0] mWd;
    logic [31:0] expRdata = 32'h0;
    logic [1:0]  expGnt;
    logic [1:0]  expResp;
    logic        expWe;
    logic [27:0] expA;
    logic [31:0] expWd;
    logic [31:0] oldWord;

    always @(negedge clk) begin
        if (!rstN) begin
            pending  = 1'b0;
            rrPtr    = 0;
            expRdata = 32'h0;
            checkOutput("rst_gnt",   32'(gnt),   32'h0);
            checkOutput("rst_resp",  32'(resp),  32'h0);
            checkOutput("rst_we",    32'(memWe), 32'h0);
            checkOutput("rst_mem_a", 32'(memA),  32'h0);
            checkOutput("rst_mem_wd", memWd,     32'h0);
            checkOutput("rst_rdata", rdata,      32'h0);
        end else begin
            expGnt = 2'b00;
            win    = 0;
            if (!pending && req != 2'b00) begin
                win    = req[rrPtr[0]] ? rrPtr : 1 - rrPtr;
                expGnt = 2'(1 << win);
            end
            checkOutput("gnt", 32'(gnt), 32'(expGnt));

            expResp    = 2'b00;
            expWe      = 1'b0;
            expA       = '0;
            expWd      = '0;
            wasPending = pending;
            if (pending) begin
                cnt--;
                oldWord = refWord(mAddr);
                if (cnt >= 1) expA = mAddr;
                if (cnt == 1 && mWe) begin
                    expWe = 1'b1;
                    if (mSub && mF3 == 3'd0)      expWd = {oldWord[31:8], mWd[7:0]};
                    else if (mSub)                expWd = {oldWord[31:16], mWd[15:0]};
                    else                          expWd = mWd;
                end
                if (cnt == 0) begin
                    expResp = 2'(1 << mPort);
                    if (!mWe) begin
                        expRdata = loadValue(mF3, oldWord);
                    end else begin
                        refMem[mAddr[9:0]] = mWd[7:0];
                        if (!(mSub && mF3 == 3'd0)) refMem[mAddr[9:0] + 10'd1] = mWd[15:8];
                        if (!mSub) begin
                            refMem[mAddr[9:0] + 10'd2] = mWd[23:16];
                            refMem[mAddr[9:0] + 10'd3] = mWd[31:24];
                        end
                    end
                    pending = 1'b0;
                end
            end
            checkOutput("resp",  32'(resp),  32'(expResp));
            checkOutput("mem_we", 32'(memWe), 32'(expWe));
            checkOutput("mem_a", 32'(memA),  32'(expA));
            checkOutput("rdata", rdata,      expRdata);
            if (expWe || !wasPending) checkOutput("mem_wd", memWd, expWd);

            if (expGnt != 2'b00) begin
                pending = 1'b1;
                mPort   = win;
                mWe     = reqWe[win[0]];
                mF3     = reqF3[win[0]];
                mAddr   = reqAddr[win[0]];
                mWd     = reqWdata[win[0]];
                mSub    = mWe && (mF3 == 3'd0 || mF3 == 3'd1);
                cnt     = mSub ? 3 : 2;
                rrPtr   = (win + 1) % 2;
            end
        end
    end

    // One request from one port: wait for its grant, drop it, wait for completion.
    task automatic applyStimulus(input bit port, input bit we, input logic [2:0] f3,
                                 input logic [27:0] addr, input logic [31:0] wd,
                                 output int lat, output logic [31:0] rd);
        int gc;
        bit got;
        lat = -1;
        rd  = '0;
        gc  = 0;
        @(posedge clk); #1;
        req[port]      = 1'b1;
        reqWe[port]    = we;
        reqF3[port]    = f3;
        reqAddr[port]  = addr;
        reqWdata[port] = wd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gnt[port]) begin
                got = 1'b1;
                gc  = cyc;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("[TB] FAIL gnt_timeout: got no grant, want grant on port %0d", port);
            req[port] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req[port] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (resp[port]) begin
                got = 1'b1;
                lat = cyc - gc;
                rd  = rdata;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("[TB] FAIL resp_timeout: got no response, want response on port %0d", port);
        end
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rstN = 1'b0;
        req  = 2'b00;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
    endtask

    int          lat;
    logic [31:0] rd;
    logic [1:0]  grants[$];
    bit          weSeen;
    bit          got;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = 8'(i) ^ 8'h5A;
            refMem[i] = 8'(i) ^ 8'h5A;
        end
        rstN     = 1'b0;
        req      = 2'b00;
        reqWe    = 2'b00;
        reqF3    = '0;
        reqAddr  = '0;
        reqWdata = '0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;

        // Word store then word load
        applyStimulus(1'b0, 1'b1, 3'b010, 28'h10000, 32'hDEADBEEF, lat, rd);
        checkOutput("sw_latency", 32'(lat), 32'd2);
        applyStimulus(1'b0, 1'b0, 3'b010, 28'h10000, 32'h0, lat, rd);
        checkOutput("lw_latency", 32'(lat), 32'd2);
        checkOutput("lw_data", rd, 32'hDEADBEEF);

        // Unaligned byte store (read-modify-write)
        applyStimulus(1'b0, 1'b1, 3'b000, 28'h10001, 32'h123456A5, lat, rd);
        checkOutput("sb_latency", 32'(lat), 32'd3);
        checkOutput("sb_rdata_kept", rd, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 3'b010, 28'h10000, 32'h0, lat, rd);
        checkOutput("lw_after_sb", rd, 32'hDEADA5EF);
        checkOutput("byte4_intact", 32'(ram[4]), 32'h0000005E);

        // Sized loads with extension
        applyStimulus(1'b0, 1'b0, 3'b000, 28'h10001, 32'h0, lat, rd);
        checkOutput("lb", rd, 32'hFFFFFFA5);
        applyStimulus(1'b1, 1'b0, 3'b100, 28'h10001, 32'h0, lat, rd);
        checkOutput("lbu", rd, 32'h000000A5);
        applyStimulus(1'b1, 1'b0, 3'b001, 28'h10002, 32'h0, lat, rd);
        checkOutput("lh", rd, 32'hFFFFDEAD);
        checkOutput("lh_latency", 32'(lat), 32'd2);
        applyStimulus(1'b0, 1'b0, 3'b101, 28'h10002, 32'h0, lat, rd);
        checkOutput("lhu", rd, 32'h0000DEAD);

        // Both ports requesting right after reset, held continuously
        doReset();
        req      = 2'b11;
        reqWe    = 2'b00;
        reqF3[0] = 3'b010; reqAddr[0] = 28'h10000;
        reqF3[1] = 3'b101; reqAddr[1] = 28'h10002;
        grants.delete();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) grants.push_back(gnt);
        end
        @(posedge clk); #1 req = 2'b00;
        repeat (4) @(posedge clk);
        checkOutput("arb_count_ok", 32'(grants.size() >= 4), 32'd1);
        for (int i = 0; i < grants.size(); i++) begin
            checkOutput("arb_order", 32'(grants[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Reset while a halfword store sits in its read phase
        @(posedge clk); #1;
        req[0] = 1'b1; reqWe[0] = 1'b1; reqF3[0] = 3'b001;
        reqAddr[0] = 28'h10000; reqWdata[0] = 32'hBEEF1234;
        weSeen = 1'b0;
        got    = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gnt[0]) got = 1'b1;
        end
        checkOutput("sh_granted", 32'(got), 32'd1);
        @(posedge clk); #1;
        req = 2'b00;
        if (memWe) weSeen = 1'b1;
        rstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (memWe) weSeen = 1'b1;
        end
        #1 rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (memWe) weSeen = 1'b1;
        end
        checkOutput("abort_no_we", 32'(weSeen), 32'd0);
        checkOutput("abort_rdata", rdata, 32'h0);
        applyStimulus(1'b0, 1'b0, 3'b010, 28'h10000, 32'h0, lat, rd);
        checkOutput("abort_word", rd, 32'hDEADA5EF);

        // Idle bus
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_we",   32'(memWe), 32'd0);
            checkOutput("idle_gnt",  32'(gnt),   32'd0);
            checkOutput("idle_resp", 32'(resp),  32'd0);
            checkOutput("idle_mem_a", 32'(memA), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
